line_steer_ctrl: RTL and testbench

LINE_STEER_CTRL -- requirements
Module: line_steer_ctrl

---
 rtl/line_ctrl_pkg.sv | 33 +++
 rtl/line_steer_ctrl_if.sv | 29 ++
 rtl/line_steer_ctrl_pwm_gen.sv | 46 ++++
 rtl/line_steer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_line_steer_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/line_ctrl_pkg.sv
// Shared types and default constants for the line-following steering controller.
package line_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  typedef logic [9:0]         duty_t;
  typedef logic signed [11:0] err_t;

  // Wide enough that KP*err + KD*(err-prev_err) never overflows for any 11-bit centroid.
  localparam int ACC_W = 20;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam int DEF_IMG_CENTER  = 320;
  localparam int DEF_KP          = 2;
  localparam int DEF_KD          = 1;
  localparam int DEF_SHIFT       = 2;
  localparam int DEF_BASE_DUTY   = 600;
  localparam int DEF_SEARCH_DUTY = 300;
  localparam int DEF_PWM_PERIOD  = 1000;
  localparam int DEF_LOST_FRAMES = 4;

  function automatic duty_t clamp_duty(input acc_t v, input acc_t period);
    if (v < 0) return '0;
    if (v > period) return duty_t'(period);
    return duty_t'(v);
  endfunction

endpackage

// File: rtl/line_steer_ctrl_if.sv
// Frame-result inputs and motor/debug outputs of the steering controller.
interface line_steer_ctrl_if;
  import line_ctrl_pkg::*;

  // centroid_ready is a one-cycle valid pulse with no ready/back-pressure:
  // centroid_x, line_valid and line_lost are only meaningful in that cycle.
  logic        enable;
  logic        centroid_ready;
  logic [10:0] centroid_x;
  logic        line_valid;
  logic        line_lost;

  logic        pwm_left;
  logic        pwm_right;
  duty_t       duty_left;
  duty_t       duty_right;
  logic [1:0]  state_out;

  modport master (
    output enable, centroid_ready, centroid_x, line_valid, line_lost,
    input  pwm_left, pwm_right, duty_left, duty_right, state_out
  );

  modport slave (
    input  enable, centroid_ready, centroid_x, line_valid, line_lost,
    output pwm_left, pwm_right, duty_left, duty_right, state_out
  );

endinterface

// File: rtl/line_steer_ctrl_pwm_gen.sv
// One motor PWM channel: free-running counter, shadow duty, wrap-time load, compare.
module pwm_gen
  import line_ctrl_pkg::*;
#(
  parameter int PERIOD = DEF_PWM_PERIOD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  load,
  input  duty_t duty_in,
  output logic  pwm
);

  duty_t cnt_q, cnt_d;
  duty_t shadow_q, shadow_d;
  duty_t active_q, active_d;
  logic  wrap;

  always_comb begin
    wrap     = (cnt_q == duty_t'(PERIOD - 1));
    cnt_d    = wrap ? '0 : cnt_q + 10'd1;
    shadow_d = load ? duty_in : shadow_q;
    active_d = wrap ? shadow_q : active_q;
    // The counter keeps running through clear so sibling channels stay in phase.
    if (clear) begin
      shadow_d = '0;
      active_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign pwm = (cnt_q < active_q);

endmodule

// File: rtl/line_steer_ctrl.sv
// Steering controller: 3-stage PD pipeline (latch, multiply, sum/clamp) feeding
// a track/search/stop FSM and two in-phase PWM channels.
module line_steer_ctrl
  import line_ctrl_pkg::*;
#(
  parameter int IMG_CENTER  = DEF_IMG_CENTER,
  parameter int KP          = DEF_KP,
  parameter int KD          = DEF_KD,
  parameter int SHIFT       = DEF_SHIFT,
  parameter int BASE_DUTY   = DEF_BASE_DUTY,
  parameter int SEARCH_DUTY = DEF_SEARCH_DUTY,
  parameter int PWM_PERIOD  = DEF_PWM_PERIOD,
  parameter int LOST_FRAMES = DEF_LOST_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  line_steer_ctrl_if.slave bus
);

  // Stage 1: latched frame
  logic        s1_v_q, s1_v_d;
  logic [10:0] x_q, x_d;
  logic        good1_q, good1_d;

  // Stage 2: error and products
  logic  s2_v_q, s2_v_d;
  logic  good2_q, good2_d;
  err_t  err_new;
  err_t  err_q, err_d;
  acc_t  p_q, p_d;
  acc_t  dt_q, dt_d;

  // Stage 3: commit / FSM
  state_t     state_q, state_d;
  logic [7:0] lost_cnt_q, lost_cnt_d;
  logic [7:0] lost_inc;
  err_t       prev_err_q, prev_err_d;
  duty_t      duty_l_q, duty_l_d;
  duty_t      duty_r_q, duty_r_d;
  duty_t      trk_l, trk_r;
  duty_t      srch_l, srch_r;
  acc_t       corr;
  logic       commit;

  // A new pulse kills anything in flight so only the newest frame can commit.
  always_comb begin
    s1_v_d  = bus.centroid_ready & bus.enable;
    x_d     = bus.centroid_ready ? bus.centroid_x : x_q;
    good1_d = bus.centroid_ready ? (bus.line_valid & ~bus.line_lost) : good1_q;

    err_new = $signed({1'b0, x_q}) - err_t'(IMG_CENTER);
    s2_v_d  = s1_v_q & ~bus.centroid_ready & bus.enable;
    good2_d = good1_q;
    err_d   = s1_v_q ? err_new : err_q;
    p_d     = acc_t'(KP) * acc_t'(err_new);
    // Entering TRACK from any other state suppresses the derivative kick.
    dt_d    = (state_q == ST_TRACK) ?
              acc_t'(KD) * (acc_t'(err_new) - acc_t'(prev_err_q)) : '0;

    commit  = s2_v_q & ~bus.centroid_ready & bus.enable;
  end

  always_comb begin
    corr   = (p_q + dt_q) >>> SHIFT;
    trk_l  = clamp_duty(acc_t'(BASE_DUTY) + corr, acc_t'(PWM_PERIOD));
    trk_r  = clamp_duty(acc_t'(BASE_DUTY) - corr, acc_t'(PWM_PERIOD));
    // Pivot toward the side the line was last seen on.
    srch_l = prev_err_q[11] ? '0 : duty_t'(SEARCH_DUTY);
    srch_r = prev_err_q[11] ? duty_t'(SEARCH_DUTY) : '0;
    lost_inc = (state_q == ST_TRACK) ? 8'd1 : lost_cnt_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    lost_cnt_d = lost_cnt_q;
    prev_err_d = prev_err_q;
    duty_l_d   = duty_l_q;
    duty_r_d   = duty_r_q;

    if (!bus.enable) begin
      state_d    = ST_IDLE;
      lost_cnt_d = '0;
      duty_l_d   = '0;
      duty_r_d   = '0;
    end else if (commit) begin
      if (good2_q) begin
        state_d    = ST_TRACK;
        lost_cnt_d = '0;
        prev_err_d = err_q;
        duty_l_d   = trk_l;
        duty_r_d   = trk_r;
      end else begin
        duty_l_d = '0;
        duty_r_d = '0;
        case (state_q)
          ST_TRACK, ST_SEARCH: begin
            lost_cnt_d = lost_inc;
            if (lost_inc >= 8'(LOST_FRAMES)) begin
              state_d = ST_STOP;
            end else begin
              state_d  = ST_SEARCH;
              duty_l_d = srch_l;
              duty_r_d = srch_r;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      x_q        <= '0;
      good1_q    <= 1'b0;
      s2_v_q     <= 1'b0;
      good2_q    <= 1'b0;
      err_q      <= '0;
      p_q        <= '0;
      dt_q       <= '0;
      state_q    <= ST_IDLE;
      lost_cnt_q <= '0;
      prev_err_q <= '0;
      duty_l_q   <= '0;
      duty_r_q   <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      x_q        <= x_d;
      good1_q    <= good1_d;
      s2_v_q     <= s2_v_d;
      good2_q    <= good2_d;
      err_q      <= err_d;
      p_q        <= p_d;
      dt_q       <= dt_d;
      state_q    <= state_d;
      lost_cnt_q <= lost_cnt_d;
      prev_err_q <= prev_err_d;
      duty_l_q   <= duty_l_d;
      duty_r_q   <= duty_r_d;
    end
  end

  // Both channels reset and count identically, so their periods are in phase.
  pwm_gen #(.PERIOD(PWM_PERIOD)) u_pwm_left (
    .clk     (clk),
    .rst     (rst),
    .clear   (~bus.enable),
    .load    (commit),
    .duty_in (duty_l_d),
    .pwm     (bus.pwm_left)
  );

  pwm_gen #(.PERIOD(PWM_PERIOD)) u_pwm_right (
    .clk     (clk),
    .rst     (rst),
    .clear   (~bus.enable),
    .load    (commit),
    .duty_in (duty_r_d),
    .pwm     (bus.pwm_right)
  );

  assign bus.duty_left  = duty_l_q;
  assign bus.duty_right = duty_r_q;
  assign bus.state_out  = state_q;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Self-checking bench for line_steer_ctrl: directed scenarios plus randomized frames
// scored against a behavioural model of the steering rules.
module tb_line_steer_ctrl;
  import line_ctrl_pkg::*;

  localparam int PERIOD = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_steer_ctrl_if bus ();
  line_steer_ctrl_if bus8 ();

  line_steer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  line_steer_ctrl #(.KP(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  assign bus8.enable         = bus.enable;
  assign bus8.centroid_ready = bus.centroid_ready;
  assign bus8.centroid_x     = bus.centroid_x;
  assign bus8.line_valid     = bus.line_valid;
  assign bus8.line_lost      = bus.line_lost;

  int n_checks = 0;
  int n_errors = 0;

  // PWM counter phase: 0 while in reset, then +1 per clock modulo the period.
  int phase;
  always @(posedge clk) begin
    if (rst) phase <= 0;
    else     phase <= (phase == PERIOD - 1) ? 0 : phase + 1;
  end

  // Behavioural reference state.
  int m_state, m_lost, m_prev, m_dl, m_dr;
  logic [21:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_int(input int v);
    if (v < 0) return 0;
    if (v > PERIOD) return PERIOD;
    return v;
  endfunction

  function automatic logic [21:0] pack_exp();
    return {m_state[1:0], m_dl[9:0], m_dr[9:0]};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_lost = 0; m_prev = 0; m_dl = 0; m_dr = 0;
    exp_q.delete();
  endfunction

  function automatic void model_frame(input int x, input bit v, input bit l);
    int err, d, corr;
    if (v && !l) begin
      err  = x - 320;
      d    = (m_state == 1) ? (err - m_prev) : 0;
      corr = (2 * err + d) >>> 2;
      m_dl = clamp_int(600 + corr);
      m_dr = clamp_int(600 - corr);
      m_prev = err; m_lost = 0; m_state = 1;
    end else begin
      if (m_state == 1 || m_state == 2) begin
        m_lost  = (m_state == 1) ? 1 : m_lost + 1;
        m_state = (m_lost >= 4) ? 3 : 2;
      end
      if (m_state == 2) begin
        m_dl = (m_prev >= 0) ? 300 : 0;
        m_dr = (m_prev >= 0) ? 0 : 300;
      end else begin
        m_dl = 0; m_dr = 0;
      end
    end
    exp_q.push_back(pack_exp());
  endfunction

  task automatic check_vec(input string tag, input logic [21:0] e);
    check({tag, "_state"}, 32'(bus.state_out), 32'(e[21:20]));
    check({tag, "_dl"}, 32'(bus.duty_left), 32'(e[19:10]));
    check({tag, "_dr"}, 32'(bus.duty_right), 32'(e[9:0]));
  endtask

  task automatic drive_pulse(input int x, input bit v, input bit l);
    bus.centroid_ready = 1'b1;
    bus.centroid_x     = 11'(x);
    bus.line_valid     = v;
    bus.line_lost      = l;
  endtask

  task automatic send_frame(input string tag, input int x, input bit v, input bit l);
    logic [21:0] old_v;
    old_v = pack_exp();
    model_frame(x, v, l);
    @(negedge clk); drive_pulse(x, v, l);
    @(negedge clk); bus.centroid_ready = 1'b0;
    @(negedge clk); check_vec({tag, "_lat2"}, old_v);
    @(negedge clk); check_vec({tag, "_lat3"}, exp_q.pop_front());
  endtask

  task automatic send_double(input int xa, input bit va, input bit la,
                             input int xb, input bit vb, input bit lb, input int gap);
    logic [21:0] old_v;
    old_v = pack_exp();
    model_frame(xb, vb, lb);
    @(negedge clk); drive_pulse(xa, va, la);
    if (gap == 2) begin
      @(negedge clk); bus.centroid_ready = 1'b0;
    end
    @(negedge clk); drive_pulse(xb, vb, lb);
    @(negedge clk); bus.centroid_ready = 1'b0; check_vec("dbl_old1", old_v);
    @(negedge clk); check_vec("dbl_old2", old_v);
    @(negedge clk); check_vec("dbl_new", exp_q.pop_front());
  endtask

  task automatic wait_phase(input int target);
    for (int i = 0; i < PERIOD + 2 && phase != target; i++) @(negedge clk);
    if (phase != target) check("phase_timeout", 32'(phase), 32'(target));
  endtask

  task automatic count_period(output int hl, output int hr, output int h8l, output int h8r);
    hl = 0; hr = 0; h8l = 0; h8r = 0;
    for (int i = 0; i < PERIOD; i++) begin
      hl  += int'(bus.pwm_left);
      hr  += int'(bus.pwm_right);
      h8l += int'(bus8.pwm_left);
      h8r += int'(bus8.pwm_right);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.centroid_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.state_out), 0);
    check("rst_dl", 32'(bus.duty_left), 0);
    check("rst_dr", 32'(bus.duty_right), 0);
    check("rst_pwm_l", 32'(bus.pwm_left), 0);
    check("rst_pwm_r", 32'(bus.pwm_right), 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hl, hr, h8l, h8r, x, r, gap;
    bit v, l;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.centroid_ready = 1'b0;
    bus.centroid_x = '0;
    bus.line_valid = 1'b0;
    bus.line_lost = 1'b0;

    do_reset();
    bus.enable = 1'b1;

    // High-gain instance: first frame saturates both duties.
    send_frame("s3", 639, 1, 0);
    check("s3_state8", 32'(bus8.state_out), 1);
    check("s3_dl8", 32'(bus8.duty_left), 32'(clamp_int(600 + ((8 * (639 - 320)) >>> 2))));
    check("s3_dr8", 32'(bus8.duty_right), 32'(clamp_int(600 - ((8 * (639 - 320)) >>> 2))));
    wait_phase(0);
    count_period(hl, hr, h8l, h8r);
    check("s3_hi_l", 32'(hl), 32'(m_dl));
    check("s3_hi_r", 32'(hr), 32'(m_dr));
    check("s3_hi_l8", 32'(h8l), PERIOD);
    check("s3_hi_r8", 32'(h8r), 0);

    do_reset();
    bus.enable = 1'b1;
    send_frame("s1", 360, 1, 0);
    check("s1_pwm_hold", 32'(bus.pwm_left), 0);
    wait_phase(0);
    check("s1_inphase", 32'({bus.pwm_left, bus.pwm_right}), 3);
    count_period(hl, hr, h8l, h8r);
    check("s1_hi_l", 32'(hl), 32'(m_dl));
    check("s1_hi_r", 32'(hr), 32'(m_dr));

    send_frame("s2", 400, 1, 0);

    // Enable dropped while the left channel is mid-high.
    wait_phase(100);
    check("s6_pre_pwm", 32'(bus.pwm_left), 1);
    bus.enable = 1'b0;
    @(negedge clk);
    check("s6_pwm_l", 32'(bus.pwm_left), 0);
    check("s6_pwm_r", 32'(bus.pwm_right), 0);
    check("s6_state", 32'(bus.state_out), 0);
    check("s6_dl", 32'(bus.duty_left), 0);
    m_state = 0; m_lost = 0; m_dl = 0; m_dr = 0;
    bus.enable = 1'b1;

    // Reset lands while a valid frame is in the pipeline.
    @(negedge clk); drive_pulse(500, 1, 0);
    @(negedge clk); bus.centroid_ready = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(negedge clk); check_vec("s6_rst1", pack_exp());
    @(negedge clk); check_vec("s6_rst2", pack_exp());

    send_frame("post_rst", 360, 1, 0);
    send_frame("s4_trk", 400, 1, 0);
    send_frame("s5_both", 400, 1, 1);
    send_frame("s4_lost2", 0, 0, 1);
    send_frame("s4_lost3", 0, 0, 1);
    send_frame("s4_lost4", 0, 0, 1);
    send_frame("s4_stop", 0, 0, 1);
    send_frame("s4_back", 301, 1, 0);
    send_frame("s4_mirror", 10, 0, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 700);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      if (r == 0) begin
        gap = $urandom_range(1, 2);
        send_double($urandom_range(0, 700), 1'b1, 1'b0, x, v, l, gap);
      end else if (r == 1) begin
        @(negedge clk); bus.enable = 1'b0;
        @(negedge clk);
        check("rnd_en_state", 32'(bus.state_out), 0);
        check("rnd_en_pwm", 32'({bus.pwm_left, bus.pwm_right}), 0);
        m_state = 0; m_lost = 0; m_dl = 0; m_dr = 0;
        bus.enable = 1'b1;
      end else begin
        send_frame("rnd", x, v, l);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
